// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded fields and WB-bypassed operands, detects load-use hazards.
// Latency 1 cycle; stallIn holds the stage, a load-use hazard inserts one bubble and freezes IF/ID.
module id_ex_stage_reg #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 8
) (
  input  logic              clkIn,
  input  logic              resetIn,
  input  logic              validIn,
  input  logic [XLEN-1:0]   pcIn,
  input  logic [RA_W-1:0]   rs1In,
  input  logic [RA_W-1:0]   rs2In,
  input  logic              useRs1In,
  input  logic              useRs2In,
  input  logic [RA_W-1:0]   rdIn,
  input  logic [XLEN-1:0]   immIn,
  input  logic              memReadIn,
  input  logic              regWriteIn,
  input  logic [CTRL_W-1:0] ctrlIn,
  input  logic [XLEN-1:0]   data1In,
  input  logic [XLEN-1:0]   data2In,
  input  logic [RA_W-1:0]   wbRdIn,
  input  logic [XLEN-1:0]   wbDataIn,
  input  logic              wbWriteIn,
  input  logic              flushIn,
  input  logic              stallIn,
  output logic              stallOut,
  output logic              validOut,
  output logic [XLEN-1:0]   pcOut,
  output logic [RA_W-1:0]   rs1Out,
  output logic [RA_W-1:0]   rs2Out,
  output logic [RA_W-1:0]   rdOut,
  output logic [XLEN-1:0]   immOut,
  output logic              memReadOut,
  output logic              regWriteOut,
  output logic [CTRL_W-1:0] ctrlOut,
  output logic [XLEN-1:0]   data1Out,
  output logic [XLEN-1:0]   data2Out
);

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [RA_W-1:0]   rs1;
    logic [RA_W-1:0]   rs2;
    logic [RA_W-1:0]   rd;
    logic [XLEN-1:0]   imm;
    logic              memRead;
    logic              regWrite;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   data1;
    logic [XLEN-1:0]   data2;
  } idExT;

  idExT stageQ;
  idExT stageD;
  logic hazard;

  // The regfile commits on the same edge we sample it, so a matching WB write must win.
  function automatic logic [XLEN-1:0] selOperand(
    input logic [RA_W-1:0] rs,
    input logic [XLEN-1:0] rfData,
    input logic            wbWrite,
    input logic [RA_W-1:0] wbRd,
    input logic [XLEN-1:0] wbData
  );
    if (rs == '0)                  return '0;
    else if (wbWrite && wbRd == rs) return wbData;
    else                           return rfData;
  endfunction

  assign hazard = stageQ.valid && stageQ.memRead && (stageQ.rd != '0) && validIn &&
                  ((useRs1In && rs1In == stageQ.rd) || (useRs2In && rs2In == stageQ.rd));

  assign stallOut = !flushIn && (stallIn || hazard);

  always_comb begin
    stageD = stageQ;
    if (flushIn) begin
      stageD.valid    = 1'b0;
      stageD.memRead  = 1'b0;
      stageD.regWrite = 1'b0;
      stageD.ctrl     = '0;
    end else if (stallIn) begin
      // Held operands would otherwise miss a write that retires while EX is frozen.
      if (wbWriteIn && wbRdIn != '0 && wbRdIn == stageQ.rs1) stageD.data1 = wbDataIn;
      if (wbWriteIn && wbRdIn != '0 && wbRdIn == stageQ.rs2) stageD.data2 = wbDataIn;
    end else if (hazard) begin
      stageD.valid    = 1'b0;
      stageD.memRead  = 1'b0;
      stageD.regWrite = 1'b0;
      stageD.ctrl     = '0;
    end else begin
      stageD.valid    = validIn;
      stageD.pc       = pcIn;
      stageD.rs1      = rs1In;
      stageD.rs2      = rs2In;
      stageD.rd       = rdIn;
      stageD.imm      = immIn;
      stageD.memRead  = validIn && memReadIn;
      stageD.regWrite = validIn && regWriteIn;
      stageD.ctrl     = validIn ? ctrlIn : '0;
      stageD.data1    = selOperand(rs1In, data1In, wbWriteIn, wbRdIn, wbDataIn);
      stageD.data2    = selOperand(rs2In, data2In, wbWriteIn, wbRdIn, wbDataIn);
    end
  end

  always_ff @(posedge clkIn) begin
    if (resetIn) stageQ <= '0;
    else         stageQ <= stageD;
  end

  assign validOut    = stageQ.valid;
  assign pcOut       = stageQ.pc;
  assign rs1Out      = stageQ.rs1;
  assign rs2Out      = stageQ.rs2;
  assign rdOut       = stageQ.rd;
  assign immOut      = stageQ.imm;
  assign memReadOut  = stageQ.memRead;
  assign regWriteOut = stageQ.regWrite;
  assign ctrlOut     = stageQ.ctrl;
  assign data1Out    = stageQ.data1;
  assign data2Out    = stageQ.data2;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed scenarios plus a random stream against a behavioural model.
module tb_id_ex_stage_reg;

  logic        clkIn = 1'b0;
  logic        resetIn, validIn, useRs1In, useRs2In, memReadIn, regWriteIn;
  logic        wbWriteIn, flushIn, stallIn;
  logic [31:0] pcIn, immIn, data1In, data2In, wbDataIn;
  logic [4:0]  rs1In, rs2In, rdIn, wbRdIn;
  logic [7:0]  ctrlIn;
  logic        stallOut, validOut, memReadOut, regWriteOut;
  logic [31:0] pcOut, immOut, data1Out, data2Out;
  logic [4:0]  rs1Out, rs2Out, rdOut;
  logic [7:0]  ctrlOut;

  always #5 clkIn = ~clkIn;

  id_ex_stage_reg #(.XLEN(32), .RA_W(5), .CTRL_W(8)) dut (
    .clkIn(clkIn), .resetIn(resetIn), .validIn(validIn), .pcIn(pcIn),
    .rs1In(rs1In), .rs2In(rs2In), .useRs1In(useRs1In), .useRs2In(useRs2In),
    .rdIn(rdIn), .immIn(immIn), .memReadIn(memReadIn), .regWriteIn(regWriteIn),
    .ctrlIn(ctrlIn), .data1In(data1In), .data2In(data2In), .wbRdIn(wbRdIn),
    .wbDataIn(wbDataIn), .wbWriteIn(wbWriteIn), .flushIn(flushIn), .stallIn(stallIn),
    .stallOut(stallOut), .validOut(validOut), .pcOut(pcOut), .rs1Out(rs1Out),
    .rs2Out(rs2Out), .rdOut(rdOut), .immOut(immOut), .memReadOut(memReadOut),
    .regWriteOut(regWriteOut), .ctrlOut(ctrlOut), .data1Out(data1Out), .data2Out(data2Out)
  );

  int checks = 0;
  int fails  = 0;
  bit chkEn  = 1'b0;

  // Expected stage contents; dc marks fields the flush/bubble left unspecified.
  typedef struct {
    bit        valid;
    bit [31:0] pc;
    bit [4:0]  rs1, rs2, rd;
    bit [31:0] imm;
    bit        memRead, regWrite;
    bit [7:0]  ctrl;
    bit [31:0] d1, d2;
    bit        dc;
  } mdlT;

  mdlT m = '{default: 0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit [31:0] opnd(input bit [4:0] rs, input bit [31:0] rf);
    if (rs == 5'd0) return 32'd0;
    if (wbWriteIn && wbRdIn == rs) return wbDataIn;
    return rf;
  endfunction

  function automatic bit mHazard();
    return m.valid && m.memRead && m.rd != 5'd0 && validIn &&
           ((useRs1In && rs1In == m.rd) || (useRs2In && rs2In == m.rd));
  endfunction

  function automatic mdlT mNext();
    mdlT n = m;
    if (resetIn) begin
      n = '{default: 0};
    end else if (flushIn || (!stallIn && mHazard())) begin
      n.valid = 0; n.memRead = 0; n.regWrite = 0; n.ctrl = 8'd0; n.dc = 1;
    end else if (stallIn) begin
      if (wbWriteIn && wbRdIn != 5'd0 && wbRdIn == m.rs1) n.d1 = wbDataIn;
      if (wbWriteIn && wbRdIn != 5'd0 && wbRdIn == m.rs2) n.d2 = wbDataIn;
    end else begin
      n.valid = validIn; n.pc = pcIn; n.rs1 = rs1In; n.rs2 = rs2In; n.rd = rdIn;
      n.imm = immIn;
      n.memRead  = validIn & memReadIn;
      n.regWrite = validIn & regWriteIn;
      n.ctrl     = validIn ? ctrlIn : 8'd0;
      n.d1 = opnd(rs1In, data1In);
      n.d2 = opnd(rs2In, data2In);
      n.dc = 0;
    end
    return n;
  endfunction

  always @(posedge clkIn) m <= mNext();

  always @(negedge clkIn) begin
    if (chkEn) begin
      chk("stallOut", 64'(stallOut), 64'(!flushIn && (stallIn || mHazard())));
      chk("validOut", 64'(validOut), 64'(m.valid));
      chk("memReadOut", 64'(memReadOut), 64'(m.memRead));
      chk("regWriteOut", 64'(regWriteOut), 64'(m.regWrite));
      chk("ctrlOut", 64'(ctrlOut), 64'(m.ctrl));
      if (!m.dc) begin
        chk("pcOut", 64'(pcOut), 64'(m.pc));
        chk("rs1Out", 64'(rs1Out), 64'(m.rs1));
        chk("rs2Out", 64'(rs2Out), 64'(m.rs2));
        chk("rdOut", 64'(rdOut), 64'(m.rd));
        chk("immOut", 64'(immOut), 64'(m.imm));
        chk("data1Out", 64'(data1Out), 64'(m.d1));
        chk("data2Out", 64'(data2Out), 64'(m.d2));
      end
    end
  end

  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask

  task automatic clearIns();
    validIn = 0; pcIn = 0; rs1In = 0; rs2In = 0; useRs1In = 0; useRs2In = 0; rdIn = 0;
    immIn = 0; memReadIn = 0; regWriteIn = 0; ctrlIn = 0; data1In = 0; data2In = 0;
    wbRdIn = 0; wbDataIn = 0; wbWriteIn = 0; flushIn = 0; stallIn = 0;
  endtask

  task automatic randIns();
    validIn    = ($urandom_range(0, 9) < 8);
    pcIn       = $urandom;
    rs1In      = 5'($urandom_range(0, 7));
    rs2In      = 5'($urandom_range(0, 7));
    useRs1In   = 1'($urandom_range(0, 1));
    useRs2In   = 1'($urandom_range(0, 1));
    rdIn       = 5'($urandom_range(0, 7));
    immIn      = $urandom;
    memReadIn  = ($urandom_range(0, 9) < 3);
    regWriteIn = 1'($urandom_range(0, 1));
    ctrlIn     = 8'($urandom);
    data1In    = $urandom;
    data2In    = $urandom;
    wbRdIn     = 5'($urandom_range(0, 7));
    wbDataIn   = $urandom;
    wbWriteIn  = 1'($urandom_range(0, 1));
    flushIn    = ($urandom_range(0, 99) < 8);
    stallIn    = ($urandom_range(0, 99) < 15);
  endtask

  task automatic loadX7();
    clearIns();
    validIn = 1; memReadIn = 1; regWriteIn = 1; rdIn = 5'd7; rs1In = 5'd1; useRs1In = 1;
    pcIn = 32'h40;
  endtask

  task automatic addUsesX7();
    clearIns();
    validIn = 1; regWriteIn = 1; rdIn = 5'd8; rs1In = 5'd3; useRs1In = 1;
    rs2In = 5'd7; useRs2In = 1; pcIn = 32'h44;
  endtask

  initial begin
    clearIns();
    resetIn = 1;
    randIns(); stallIn = 0;
    tick();
    chkEn = 1;
    randIns(); stallIn = 0;
    @(negedge clkIn);
    chk("reset validOut", 64'(validOut), 64'h0);
    chk("reset pcOut", 64'(pcOut), 64'h0);
    chk("reset data1Out", 64'(data1Out), 64'h0);
    chk("reset regWriteOut", 64'(regWriteOut), 64'h0);
    chk("reset stallOut", 64'(stallOut), 64'h0);
    tick();
    resetIn = 0;
    clearIns();

    // WB bypass into operand 1, then x0 stays zero
    validIn = 1; wbWriteIn = 1; wbRdIn = 5'd5; wbDataIn = 32'hCAFE0001;
    rs1In = 5'd5; data1In = 32'h1111;
    tick();
    @(negedge clkIn);
    chk("bypass data1Out", 64'(data1Out), 64'hCAFE0001);
    rs1In = 5'd0;
    tick();
    @(negedge clkIn);
    chk("x0 data1Out", 64'(data1Out), 64'h0);

    // Load-use: one bubble, then the consumer issues with x7 bypassed
    loadX7();
    tick();
    addUsesX7();
    @(negedge clkIn);
    chk("loaduse stallOut", 64'(stallOut), 64'h1);
    tick();
    wbWriteIn = 1; wbRdIn = 5'd7; wbDataIn = 32'h77770007;
    @(negedge clkIn);
    chk("bubble validOut", 64'(validOut), 64'h0);
    chk("bubble regWriteOut", 64'(regWriteOut), 64'h0);
    chk("bubble stallOut", 64'(stallOut), 64'h0);
    tick();
    wbWriteIn = 0;
    @(negedge clkIn);
    chk("issue validOut", 64'(validOut), 64'h1);
    chk("issue rdOut", 64'(rdOut), 64'h8);
    chk("issue data2Out", 64'(data2Out), 64'h77770007);

    // Flush beats both stall and hazard
    loadX7();
    tick();
    addUsesX7();
    stallIn = 1; flushIn = 1;
    @(negedge clkIn);
    chk("flush stallOut", 64'(stallOut), 64'h0);
    tick();
    clearIns();
    @(negedge clkIn);
    chk("flush validOut", 64'(validOut), 64'h0);

    // Stall hold with a write to the held source mid-stall
    validIn = 1; rs1In = 5'd9; useRs1In = 1; rdIn = 5'd4; pcIn = 32'h100;
    data1In = 32'h1234; regWriteIn = 1;
    tick();
    stallIn = 1; pcIn = 32'h200; rdIn = 5'd5; rs1In = 5'd2; data1In = 32'h0;
    tick();
    wbWriteIn = 1; wbRdIn = 5'd9; wbDataIn = 32'h0000BEEF;
    tick();
    wbWriteIn = 0;
    tick();
    stallIn = 0;
    @(negedge clkIn);
    chk("hold pcOut", 64'(pcOut), 64'h100);
    chk("hold rdOut", 64'(rdOut), 64'h4);
    chk("hold rs1Out", 64'(rs1Out), 64'h9);
    chk("hold data1Out", 64'(data1Out), 64'h0000BEEF);
    tick();

    // Random stream with occasional resets
    repeat (10000) begin
      randIns();
      resetIn = ($urandom_range(0, 499) == 0);
      tick();
    end
    resetIn = 0;
    clearIns();
    tick();
    @(negedge clkIn);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
